// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to build the parity bit (even when PARITY_ODD=0, odd when PARITY_ODD=1).

// state    | meaning
// S_IDLE   | line high, waiting for a rising edge on send
// S_START  | start bit (low) for one bit period
// S_DATA   | data bit latch[cnt], LSB first
// S_PARITY | parity over the latched bits (UART_TX_PARITY_EN only)
// S_STOP   | stop bit(s), line high, STOP_BITS bit periods
module uart_tx_param #(
   parameter int CLK_DIV    = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               send,
   input  logic [DATA_BITS-1:0]               data,
   output logic                               txd,
   output logic                               busy,
   output logic [2:0]                         state_test,
   output logic [$clog2(DATA_BITS+1)-1:0]     cnt_test
);

   localparam int BW = $clog2(CLK_DIV);
   localparam int CW = $clog2(DATA_BITS+1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4
   } state_t;
`endif

   if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
       (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
      $error("uart_tx_param: illegal parameter set");
   end

   state_t                state, state_n;
   logic [BW-1:0]         baud, baud_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic                  stop_idx, stop_n;
   logic [DATA_BITS-1:0]  latch, latch_n;
   logic [DATA_BITS-1:0]  shifted;
   logic                  send_q;
   logic                  start_req;
   logic                  bit_end;
   logic                  txd_n;

   assign start_req  = send & ~send_q;
   assign state_test = state;
   assign cnt_test   = cnt;

   // send_q resets high so a send held through reset needs a fresh low-to-high edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         baud     <= '0;
         cnt      <= '0;
         stop_idx <= 1'b0;
         latch    <= '0;
         send_q   <= 1'b1;
         txd      <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         baud     <= baud_n;
         cnt      <= cnt_n;
         stop_idx <= stop_n;
         latch    <= latch_n;
         send_q   <= send;
         txd      <= txd_n;
         busy     <= (state_n != S_IDLE);
      end
   end

   always_comb begin
      state_n = state;
      baud_n  = baud;
      cnt_n   = cnt;
      stop_n  = stop_idx;
      latch_n = latch;
      bit_end = (baud == BW'(CLK_DIV-1));
      if (state != S_IDLE) baud_n = bit_end ? '0 : baud + 1'b1;
      case (state)
         S_IDLE: begin
            if (start_req) begin
               state_n = S_START;
               latch_n = data;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_n = S_DATA;
               cnt_n   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (cnt == CW'(DATA_BITS-1)) begin
                  cnt_n  = '0;
                  stop_n = 1'b0;
`ifdef UART_TX_PARITY_EN
                  state_n = S_PARITY;
`else
                  state_n = S_STOP;
`endif
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_n = S_STOP;
               stop_n  = 1'b0;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               if (stop_idx == 1'(STOP_BITS-1)) begin
                  state_n = S_IDLE;
                  stop_n  = 1'b0;
               end else begin
                  stop_n = 1'b1;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase

      // txd is registered from the next-state view so each line level comes straight from a flop
      shifted = latch_n >> cnt_n;
      case (state_n)
         S_START:  txd_n = 1'b0;
         S_DATA:   txd_n = shifted[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: txd_n = (^latch_n) ^ (PARITY_ODD != 0);
`endif
         default:  txd_n = 1'b1;
      endcase
   end

endmodule
